// File: rtl/ps2_lane_pkg.sv
// Shared types and constants for the PS/2 four-lane rhythm-game controller.
// Holds the decoder state encoding, scan-code prefixes and the ignore list.
package ps2_lane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;

  localparam logic [7:0] IGN_ACK    = 8'hFA;
  localparam logic [7:0] IGN_BAT    = 8'hAA;
  localparam logic [7:0] IGN_ECHO   = 8'hEE;
  localparam logic [7:0] IGN_RESEND = 8'hFE;
  localparam logic [7:0] IGN_ERR    = 8'h00;

  // Keyboard status/handshake bytes that must never be taken as key codes.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_ACK) || (b == IGN_BAT) || (b == IGN_ECHO) ||
           (b == IGN_RESEND) || (b == IGN_ERR);
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter 00..99 with synchronous clear (priority) and wrap.
module bcd_counter2
  import ps2_lane_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output bcd_digit_t o_ones,
  output bcd_digit_t o_tens
);

  bcd_digit_t r_ones;
  bcd_digit_t r_tens;

  // Digit registers: clear beats increment; 99 rolls over to 00.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (i_clr) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (i_inc) begin
      if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign o_ones = r_ones;
  assign o_tens = r_tens;

endmodule

// File: rtl/ps2_lane_controller.sv
// Decodes PS/2 make/break sequences into four game lanes and keeps a BCD
// score plus a saturating miss counter.
module ps2_lane_controller
  import ps2_lane_pkg::*;
#(
  parameter logic [7:0] LANE0_CODE = 8'h1C,
  parameter logic [7:0] LANE1_CODE = 8'h1B,
  parameter logic [7:0] LANE2_CODE = 8'h23,
  parameter logic [7:0] LANE3_CODE = 8'h2B
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       target_valid,
  input  logic [1:0] target_lane,
  input  logic       clear_score,
  output logic [3:0] lane_held,
  output logic [3:0] lane_hit,
  output logic       hit_ok,
  output logic       hit_miss,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [7:0] miss_count,
  output logic [7:0] last_code
);

  dec_state_t r_state;
  logic [3:0] r_held;
  logic [3:0] r_hit;
  logic       r_ok;
  logic       r_miss;
  logic [7:0] r_miss_cnt;
  logic [7:0] r_last;

  logic [3:0] w_match;
  logic [1:0] w_lane_idx;
  logic       w_is_make;
  logic       w_fresh;
  logic       w_on_target;

  // Lane lookup for the current byte and classification of a fresh press.
  always_comb begin
    w_match[0] = (ps2_key_data == LANE0_CODE);
    w_match[1] = (ps2_key_data == LANE1_CODE);
    w_match[2] = (ps2_key_data == LANE2_CODE);
    w_match[3] = (ps2_key_data == LANE3_CODE);
    if (w_match[3]) begin
      w_lane_idx = 2'd3;
    end else if (w_match[2]) begin
      w_lane_idx = 2'd2;
    end else if (w_match[1]) begin
      w_lane_idx = 2'd1;
    end else begin
      w_lane_idx = 2'd0;
    end
    w_is_make   = ps2_key_pressed && (r_state == ST_IDLE) &&
                  (ps2_key_data != PS2_BREAK) && (ps2_key_data != PS2_EXT) &&
                  !is_ignored(ps2_key_data);
    w_fresh     = w_is_make && (|w_match) && !r_held[w_lane_idx];
    w_on_target = target_valid && (target_lane == w_lane_idx);
  end

  // Decoder FSM with lane state, one-cycle pulses and miss counter.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_held     <= 4'd0;
      r_hit      <= 4'd0;
      r_ok       <= 1'b0;
      r_miss     <= 1'b0;
      r_miss_cnt <= 8'd0;
      r_last     <= 8'd0;
    end else begin
      r_hit  <= 4'd0;
      r_ok   <= w_fresh && w_on_target && !clear_score;
      r_miss <= w_fresh && !w_on_target && !clear_score;
      if (clear_score) begin
        r_miss_cnt <= 8'd0;
      end else if (w_fresh && !w_on_target && (r_miss_cnt != 8'hFF)) begin
        r_miss_cnt <= r_miss_cnt + 8'd1;
      end
      if (ps2_key_pressed) begin
        case (r_state)
          ST_IDLE: begin
            if (ps2_key_data == PS2_BREAK) begin
              r_state <= ST_BRK;
            end else if (ps2_key_data == PS2_EXT) begin
              r_state <= ST_EXT;
            end else if (!is_ignored(ps2_key_data)) begin
              r_last <= ps2_key_data;
              if (w_fresh) begin
                r_held[w_lane_idx] <= 1'b1;
                r_hit[w_lane_idx]  <= 1'b1;
              end
            end
          end
          ST_BRK: begin
            r_state <= ST_IDLE;
            r_last  <= ps2_key_data;
            if (|w_match) begin
              r_held[w_lane_idx] <= 1'b0;
            end
          end
          ST_EXT: begin
            r_state <= (ps2_key_data == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
          end
          ST_EXT_BRK: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  bcd_counter2 u_score (
    .i_clk   (CLOCK_50),
    .i_rst_n (resetn),
    .i_clr   (clear_score),
    .i_inc   (w_fresh && w_on_target),
    .o_ones  (score_ones),
    .o_tens  (score_tens)
  );

  assign lane_held  = r_held;
  assign lane_hit   = r_hit;
  assign hit_ok     = r_ok;
  assign hit_miss   = r_miss;
  assign miss_count = r_miss_cnt;
  assign last_code  = r_last;

endmodule
